// File: rtl/axi4l_cnt_reg_file.sv
// AXI4-Lite slave register file: CTRL, STATUS, SCRATCH, free-running event COUNTER and ID.
// Single-beat write/read channels, one outstanding transaction per direction.
module axi4l_cnt_reg_file #(
    parameter int                                    AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int                                    AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   BASE_ADDR                = '0,
    parameter logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   ID_VALUE                 = 32'h4D59_0001
) (
    input  logic                                     i_clk,
    input  logic                                     i_arst_n,
    input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]      i_awaddr,
    input  logic                                     i_awvalid,
    output logic                                     o_awready,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]      i_wdata,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0]    i_wstrb,
    input  logic                                     i_wvalid,
    output logic                                     o_wready,
    output logic [1:0]                               o_bresp,
    output logic                                     o_bvalid,
    input  logic                                     i_bready,
    input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]      i_araddr,
    input  logic                                     i_arvalid,
    output logic                                     o_arready,
    output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]      o_rdata,
    output logic [1:0]                               o_rresp,
    output logic                                     o_rvalid,
    input  logic                                     i_rready,
    input  logic                                     i_event,
    output logic                                     o_enable
);

    localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int DW = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int SW = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_STATUS  = 3'd1,
        REG_SCRATCH = 3'd2,
        REG_COUNTER = 3'd3,
        REG_ID      = 3'd4
    } reg_idx_e;

    if (DW != 32) begin : g_bad_data_width
        $error("AXI4_LITE_DATA_BIT_WIDTH must be 32");
    end
    if (AW < 8) begin : g_bad_addr_width
        $error("AXI4_LITE_ADDR_BIT_WIDTH must be at least 8");
    end
    if (BASE_ADDR[4:0] != 5'd0) begin : g_bad_base_addr
        $error("BASE_ADDR must be 32-byte aligned");
    end

    logic          ctrl_en;
    logic          sticky_ovf;
    logic [DW-1:0] scratch;
    logic [DW-1:0] counter;

    logic          wr_hs;
    logic          rd_hs;
    logic          wr_in_range;
    logic          rd_in_range;
    logic          wr_ok;
    logic          ctrl_wr;
    logic          clr_pulse;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;

    // Word-aligned decode: byte-lane address bits carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_awaddr[1:0], i_araddr[1:0]};

    // Reset gates the handshakes so a master holding valid through reset sees no ready.
    assign wr_hs = i_arst_n & i_awvalid & i_wvalid & ~o_bvalid;
    assign rd_hs = i_arst_n & i_arvalid & ~o_rvalid;

    assign o_awready = wr_hs;
    assign o_wready  = wr_hs;
    assign o_arready = rd_hs;
    assign o_enable  = ctrl_en;

    assign wr_in_range = (i_awaddr[AW-1:5] == BASE_ADDR[AW-1:5]);
    assign rd_in_range = (i_araddr[AW-1:5] == BASE_ADDR[AW-1:5]);
    assign wr_ok       = wr_in_range && (i_awaddr[4:2] <= REG_ID);
    assign ctrl_wr     = wr_hs && wr_in_range && (i_awaddr[4:2] == REG_CTRL) && i_wstrb[0];
    assign clr_pulse   = ctrl_wr && i_wdata[1];

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (rd_in_range) begin
            rd_resp = RESP_OKAY;
            case (i_araddr[4:2])
                REG_CTRL:    rd_data = {{(DW-1){1'b0}}, ctrl_en};
                REG_STATUS:  rd_data = {{(DW-2){1'b0}}, sticky_ovf, ctrl_en};
                REG_SCRATCH: rd_data = scratch;
                REG_COUNTER: rd_data = counter;
                REG_ID:      rd_data = ID_VALUE;
                default:     rd_resp = RESP_SLVERR;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_bvalid <= 1'b0;
            o_bresp  <= RESP_OKAY;
        end else if (wr_hs) begin
            o_bvalid <= 1'b1;
            o_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (i_bready) begin
            o_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
            o_rresp  <= RESP_OKAY;
        end else if (rd_hs) begin
            o_rvalid <= 1'b1;
            o_rdata  <= rd_data;
            o_rresp  <= rd_resp;
        end else if (i_rready) begin
            o_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ctrl_en <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_en <= i_wdata[0];
        end
    end

    // NOTE: SCRATCH is a single architectural register with a defined reset value, so it is reset like any other flop.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            scratch <= '0;
        end else if (wr_hs && wr_in_range && (i_awaddr[4:2] == REG_SCRATCH)) begin
            for (int b = 0; b < SW; b++) begin
                if (i_wstrb[b]) begin
                    scratch[8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // CLR wins over a same-cycle increment; the overflow flag only ever sets on the wrap.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            counter    <= '0;
            sticky_ovf <= 1'b0;
        end else if (clr_pulse) begin
            counter    <= '0;
            sticky_ovf <= 1'b0;
        end else if (ctrl_en && i_event) begin
            counter <= counter + DW'(1);
            if (&counter) begin
                sticky_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4l_cnt_reg_file.sv
// Self-checking bench for axi4l_cnt_reg_file: directed plus randomised AXI4-Lite traffic
// compared against a register-level model of the block.
module tb_axi4l_cnt_reg_file;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        evt;
    logic        enable;

    int total = 0;
    int bad   = 0;

    // Register-level model of the block.
    logic        m_en;
    logic        m_ovf;
    logic [31:0] m_scratch;
    longint      m_cnt;

    localparam logic [31:0] ID_VAL = 32'h4D59_0001;
    localparam longint      WRAP   = 64'h1_0000_0000;

    axi4l_cnt_reg_file dut (
        .i_clk     (clk),
        .i_arst_n  (rst_n),
        .i_awaddr  (awaddr),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wstrb   (wstrb),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bresp   (bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .i_araddr  (araddr),
        .i_arvalid (arvalid),
        .o_arready (arready),
        .o_rdata   (rdata),
        .o_rresp   (rresp),
        .o_rvalid  (rvalid),
        .i_rready  (rready),
        .i_event   (evt),
        .o_enable  (enable)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb, output logic [1:0] resp);
        int idx;
        idx  = int'(addr[4:2]);
        resp = 2'b10;
        if (addr[31:5] == 27'd0 && idx <= 4) begin
            resp = 2'b00;
            if (idx == 0 && strb[0]) begin
                m_en = data[0];
                if (data[1]) begin
                    m_cnt = 0;
                    m_ovf = 1'b0;
                end
            end else if (idx == 2) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
            end
        end
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                       output logic [1:0] resp);
        data = 32'd0;
        resp = 2'b10;
        if (addr[31:5] == 27'd0) begin
            resp = 2'b00;
            case (int'(addr[4:2]))
                0:       data = {31'd0, m_en};
                1:       data = {30'd0, m_ovf, m_en};
                2:       data = m_scratch;
                3:       data = m_cnt[31:0];
                4:       data = ID_VAL;
                default: resp = 2'b10;
            endcase
        end
    endfunction

    function automatic void model_events(input int n);
        if (m_en) begin
            m_cnt = m_cnt + n;
            if (m_cnt >= WRAP) begin
                m_ovf = 1'b1;
                m_cnt = m_cnt % WRAP;
            end
        end
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        #1;
        while (awready !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("aw_accept", {31'd0, awready}, 32'd1);
        check("w_accept", {31'd0, wready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_next_cycle", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_drop", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        #1;
        while (arready !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("ar_accept", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid_next_cycle", {31'd0, rvalid}, 32'd1);
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_drop", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] got, exp;
        axi_write(addr, data, strb, got);
        model_write(addr, data, strb, exp);
        check({tag, "_bresp"}, {30'd0, got}, {30'd0, exp});
        check({tag, "_enable"}, {31'd0, enable}, {31'd0, m_en});
    endtask

    task automatic rd(input string tag, input logic [31:0] addr);
        logic [31:0] got_d, exp_d;
        logic [1:0]  got_r, exp_r;
        axi_read(addr, got_d, got_r);
        model_read(addr, exp_d, exp_r);
        check({tag, "_rdata"}, got_d, exp_d);
        check({tag, "_rresp"}, {30'd0, got_r}, {30'd0, exp_r});
    endtask

    task automatic pulse_events(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            evt = 1'b1;
        end
        @(negedge clk);
        evt = 1'b0;
        model_events(n);
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_ovf = 1'b0; m_scratch = 32'd0; m_cnt = 0;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] old_scratch;
        logic [31:0] held_rdata;
        logic [1:0]  held_bresp;
        int          acc;

        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0; evt = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
        check("rst_enable", {31'd0, enable}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        rd("id", 32'h10);
        check("id_const", rdata, 32'h4D59_0001);
        rd("counter_reset", 32'h0C);

        // SCRATCH byte strobes
        wr("scr_full", 32'h08, 32'hA5A5_A5A5, 4'b1111);
        wr("scr_partial", 32'h08, 32'h1234_5678, 4'b0101);
        rd("scr_merge", 32'h08);
        check("scr_merge_const", rdata, 32'hA534_A578);

        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            wr("scr_rand", 32'h08, d, s);
            rd("scr_rand", 32'h08);
        end

        // Counter enable, count and clear
        wr("ctrl_en", 32'h00, 32'h1, 4'b0001);
        pulse_events(10);
        rd("cnt_10", 32'h0C);
        check("cnt_10_const", rdata, 32'd10);
        rd("status_en", 32'h04);
        wr("ctrl_clr", 32'h00, 32'h3, 4'b1111);
        rd("cnt_cleared", 32'h0C);
        rd("ctrl_readback", 32'h00);
        wr("ctrl_nostrb", 32'h00, 32'h0000_0002, 4'b1110);
        rd("ctrl_nostrb", 32'h00);

        for (int i = 0; i < 3; i++) begin
            pulse_events($urandom_range(1, 20));
            rd("cnt_rand", 32'h0C);
        end

        // Wrap and sticky overflow
        wr("ctrl_off", 32'h00, 32'h0, 4'b0001);
        @(negedge clk);
        force dut.counter = 32'hFFFF_FFFE;
        #1;
        release dut.counter;
        m_cnt = 64'hFFFF_FFFE;
        pulse_events(3);
        rd("cnt_hold_disabled", 32'h0C);
        wr("ctrl_on", 32'h00, 32'h1, 4'b0001);
        pulse_events(2);
        rd("cnt_wrap", 32'h0C);
        rd("status_ovf", 32'h04);
        check("status_ovf_const", rdata, 32'h3);
        pulse_events(4);
        rd("status_sticky", 32'h04);
        wr("ctrl_clr_ovf", 32'h00, 32'h3, 4'b0001);
        rd("status_after_clr", 32'h04);
        check("status_after_clr_const", rdata, 32'h1);

        // Reserved, out-of-range and read-only accesses
        rd("rsvd_18", 32'h18);
        wr("oor_40", 32'h40, 32'hFFFF_FFFF, 4'b1111);
        wr("oor_48_alias", 32'h48, 32'hDEAD_BEEF, 4'b1111);
        wr("rsvd_14", 32'h14, 32'hFFFF_FFFF, 4'b1111);
        wr("ro_status", 32'h04, 32'hFFFF_FFFF, 4'b1111);
        wr("ro_id", 32'h10, 32'h0, 4'b1111);
        rd("scr_untouched", 32'h08);
        rd("ctrl_untouched", 32'h00);
        for (int i = 0; i < 6; i++) begin
            rd("rand_addr", 32'($urandom_range(0, 15)) * 32'd4);
        end

        // AW presented five cycles ahead of W
        @(negedge clk);
        d = $urandom;
        awaddr = 32'h08; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (awready === 1'b1 || wready === 1'b1) acc++;
            @(negedge clk);
        end
        check("aw_only_no_accept", acc, 0);
        wvalid = 1'b1;
        #1;
        check("aw_w_accept", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        begin
            logic [1:0] r;
            model_write(32'h08, d, 4'hF, r);
        end
        check("aw_w_single_bvalid", {31'd0, bvalid}, 32'd1);
        @(posedge clk); #1;
        bready = 1'b0;
        check("aw_w_bdone", {31'd0, bvalid}, 32'd0);
        rd("aw_w_scr", 32'h08);

        // Backpressure with simultaneous read and write of SCRATCH
        @(negedge clk);
        old_scratch = m_scratch;
        d = $urandom;
        awaddr = 32'h08; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
        #1;
        check("bp_awready", {31'd0, awready}, 32'd1);
        check("bp_arready", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        begin
            logic [1:0] r;
            model_write(32'h08, d, 4'hF, r);
        end
        wdata = ~d;
        held_rdata = rdata;
        held_bresp = bresp;
        check("bp_pre_write_read", held_rdata, old_scratch);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("bp_bvalid_hold", {31'd0, bvalid}, 32'd1);
            check("bp_rvalid_hold", {31'd0, rvalid}, 32'd1);
            check("bp_rdata_hold", rdata, old_scratch);
            check("bp_bresp_hold", {30'd0, bresp}, 32'd0);
            check("bp_awready_low", {31'd0, awready}, 32'd0);
            check("bp_arready_low", {31'd0, arready}, 32'd0);
        end

        // Reset in the middle of both pending responses
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("mid_rst_ready", {30'd0, awready, arready}, 32'd0);
        check("mid_rst_enable", {31'd0, enable}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_bvalid", {31'd0, bvalid}, 32'd0);
        check("post_rst_no_rvalid", {31'd0, rvalid}, 32'd0);
        bready = 1'b0; rready = 1'b0;
        rd("post_rst_scr", 32'h08);
        rd("post_rst_cnt", 32'h0C);
        rd("post_rst_status", 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4l_cnt_reg_file.md
Name: axi4l_cnt_reg_file

Overview:
- AXI4-Lite slave register file; it is the DUT that the UVM register-model bench drives through its AXI4-Lite agent.
- Contains a control register, a scratch register, a read-only status register, an ID register, and a free-running 32-bit event counter.
- Sits directly downstream of the bench's AXI4-Lite master agent, which uses 32-bit address and data buses and an 8 ns clock.

Parameters:
- AXI4_LITE_ADDR_BIT_WIDTH, 32, address bus width (>=8).
- AXI4_LITE_DATA_BIT_WIDTH, 32, data bus width; only 32 is legal, elaboration fails otherwise.
- BASE_ADDR, 32'h0000_0000, block base address; must be 32-byte aligned.
- ID_VALUE, 32'h4D59_0001, constant returned by the ID register.

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_awaddr  in  ADDR_W  write address.
- i_awvalid  in  1  write-address valid.
- o_awready  out  1  write-address ready.
- i_wdata  in  DATA_W  write data.
- i_wstrb  in  DATA_W/8  byte write strobes.
- i_wvalid  in  1  write-data valid.
- o_wready  out  1  write-data ready.
- o_bresp  out  2  write response.
- o_bvalid  out  1  write-response valid.
- i_bready  in  1  write-response ready.
- i_araddr  in  ADDR_W  read address.
- i_arvalid  in  1  read-address valid.
- o_arready  out  1  read-address ready.
- o_rdata  out  DATA_W  read data.
- o_rresp  out  2  read response.
- o_rvalid  out  1  read valid.
- i_rready  in  1  read-data ready.
- i_event  in  1  counter increment pulse, synchronous to i_clk.
- o_enable  out  1  CTRL.EN, for external logic.

Behaviour:
- Reset (async assert, sync deassert at the flops):
  - all ready/valid outputs 0; o_bresp = 0, o_rresp = 0, o_rdata = 0.
  - CTRL = 0, SCRATCH = 0, COUNTER = 0, STICKY_OVF = 0.
  - Reset asserted mid-transaction aborts it; no response is issued after reset.
- Address decode:
  - offset = addr - BASE_ADDR; addr[1:0] ignored.
  - In-range means addr[ADDR_W-1:5] matches BASE_ADDR[ADDR_W-1:5].
- Register map (offset):
  - 0x00 CTRL, RW: bit0 EN, bit1 CLR (write-1 pulse, reads 0), bits[31:2] read 0.
  - 0x04 STATUS, RO: bit0 EN mirror, bit1 STICKY_OVF.
  - 0x08 SCRATCH, RW, honours WSTRB per byte.
  - 0x0C COUNTER, RO.
  - 0x10 ID, RO, returns ID_VALUE.
  - 0x14-0x1C: reserved.
- Response codes:
  - Reserved or out-of-range address: SLVERR (2'b10); read data 0; write has no effect.
  - Writes to RO registers: OKAY, ignored.
- Write channel:
  - o_awready = o_wready = 1 for exactly one cycle, in the cycle where i_awvalid & i_wvalid & !o_bvalid.
  - AW-only or W-only valid: wait, no acceptance.
  - Register update happens at the handshake edge.
  - o_bvalid rises the next cycle and holds with a stable o_bresp until i_bready.
  - One outstanding write at most.
- Read channel:
  - o_arready = 1 in the cycle i_arvalid & !o_rvalid.
  - Register value sampled at the handshake edge (pre-write value if a simultaneous write occurs).
  - o_rvalid the next cycle; o_rdata/o_rresp stable until i_rready.
  - One outstanding read at most.
  - Read and write channels are independent and may handshake in the same cycle.
- CTRL write with WSTRB[0] = 0: EN and CLR unchanged/not pulsed.
- Counter:
  - When EN = 1 and i_event = 1, COUNTER increments by 1 each cycle.
  - Wraps 0xFFFF_FFFF -> 0 and sets STICKY_OVF.
  - CLR pulse sets COUNTER = 0 and STICKY_OVF = 0 on the handshake edge; CLR takes priority over a same-cycle increment.
  - STICKY_OVF clears only via CLR or reset.
- o_enable = CTRL.EN, registered, zero extra latency from the write edge.

Test Plan:
- Reset, then read 0x10 -> RDATA 0x4D59_0001, OKAY; read 0x0C -> 0.
- Write SCRATCH 0xA5A5_A5A5 with WSTRB 4'b1111, then write 0x1234_5678 with WSTRB 4'b0101 -> read returns 0xA534_A578; BVALID one cycle after handshake.
- Write CTRL = 1, drive i_event for 10 cycles -> COUNTER = 10, STATUS = 0x1; write CTRL = 0x3 -> COUNTER = 0, EN stays 1.
- Hold COUNTER at 0xFFFF_FFFE, then 2 events -> COUNTER = 0, STATUS = 0x3; write CTRL = 0x3 -> STATUS = 0x1.
- Read 0x18 and write 0x40 (out of range) -> SLVERR, RDATA 0, no state change; AW presented 5 cycles before W -> single acceptance when W arrives.
- Hold BREADY/RREADY low for 4 cycles -> BVALID/RVALID and data held stable, AWREADY/ARREADY stay 0; assert i_arst_n low mid-response -> all valids drop to 0 immediately.
